// File: rtl/axi_mem_pkg.sv
// Shared encodings, FSM state types and sizing helpers for the AXI4 memory model.
package axi_mem_pkg;

    // AXI4 burst type encodings; 2'b11 is reserved and handled like INCR
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Ceiling log2, used for address-to-word index conversion
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // A zero-width user field still needs a 1-bit port
    function automatic int port_w(input int w);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/axi_burst_addr_next.sv
// Next-beat address generator for AXI4 FIXED / INCR / WRAP bursts.
module axi_burst_addr_next
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] addr_next
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr;

    // WRAP keeps the upper bits of the (LEN+1)*step aligned window and wraps the offset
    always_comb begin
        step      = ADDR_W'(1) << size;
        wrap_mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
        incr      = addr + step;
        case (burst)
            BURST_FIXED: addr_next = addr;
            BURST_WRAP:  addr_next = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     addr_next = incr;
        endcase
    end

endmodule

// File: rtl/virtual_axi_full_memory.sv
// AXI4 slave memory model: independent single-outstanding write and read paths
// over a word array whose untouched words read back as their own index.
module virtual_axi_full_memory
    import axi_mem_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH     = 1,
    parameter int C_S_AXI_DATA_WIDTH   = 128,
    parameter int C_S_AXI_ADDR_WIDTH   = 64,
    parameter int C_S_AXI_AWUSER_WIDTH = 0,
    parameter int C_S_AXI_ARUSER_WIDTH = 0,
    parameter int C_S_AXI_WUSER_WIDTH  = 0,
    parameter int C_S_AXI_RUSER_WIDTH  = 0,
    parameter int C_S_AXI_BUSER_WIDTH  = 0,
    parameter int MEM_DEPTH            = 4096
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [7:0]                             S_AXI_AWLEN,
    input  logic [2:0]                             S_AXI_AWSIZE,
    input  logic [1:0]                             S_AXI_AWBURST,
    input  logic                                   S_AXI_AWLOCK,
    input  logic [3:0]                             S_AXI_AWCACHE,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic [3:0]                             S_AXI_AWQOS,
    input  logic [3:0]                             S_AXI_AWREGION,
    input  logic [port_w(C_S_AXI_AWUSER_WIDTH)-1:0] S_AXI_AWUSER,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WLAST,
    input  logic [port_w(C_S_AXI_WUSER_WIDTH)-1:0]  S_AXI_WUSER,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_BID,
    output logic [1:0]                             S_AXI_BRESP,
    output logic [port_w(C_S_AXI_BUSER_WIDTH)-1:0]  S_AXI_BUSER,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [7:0]                             S_AXI_ARLEN,
    input  logic [2:0]                             S_AXI_ARSIZE,
    input  logic [1:0]                             S_AXI_ARBURST,
    input  logic                                   S_AXI_ARLOCK,
    input  logic [3:0]                             S_AXI_ARCACHE,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic [3:0]                             S_AXI_ARQOS,
    input  logic [3:0]                             S_AXI_ARREGION,
    input  logic [port_w(C_S_AXI_ARUSER_WIDTH)-1:0] S_AXI_ARUSER,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]            S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RLAST,
    output logic [port_w(C_S_AXI_RUSER_WIDTH)-1:0]  S_AXI_RUSER,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int IW       = C_S_AXI_ID_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = clogb2(STRB_W);
    localparam int IDX_W    = clogb2(MEM_DEPTH);

    // Storage: a word reads as its own index until its first write marks it.
    logic [DW-1:0]        mem_q [MEM_DEPTH];
    logic [MEM_DEPTH-1:0] written_q = '0;

    // Write path state
    w_state_e      w_state_q, w_state_d;
    logic [IW-1:0] aw_id_q, aw_id_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]    aw_len_q, aw_len_d;
    logic [2:0]    aw_size_q, aw_size_d;
    logic [1:0]    aw_burst_q, aw_burst_d;
    logic [7:0]    w_cnt_q, w_cnt_d;
    logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [AW-1:0] w_addr_next;
    logic          w_fire;
    logic [IDX_W-1:0] w_idx;
    logic [DW-1:0] w_old_word, wr_word_d;

    // Read path state
    r_state_e      r_state_q, r_state_d;
    logic [IW-1:0] ar_id_q, ar_id_d;
    logic [AW-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]    ar_len_q, ar_len_d;
    logic [2:0]    ar_size_q, ar_size_d;
    logic [1:0]    ar_burst_q, ar_burst_d;
    logic [7:0]    r_cnt_q, r_cnt_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] r_gen_addr, r_addr_next;
    logic [2:0]    r_gen_size;
    logic [7:0]    r_gen_len;
    logic [1:0]    r_gen_burst;
    logic [IDX_W-1:0] r_idx;
    logic [DW-1:0] r_word;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                             S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WLAST, S_AXI_WUSER,
                             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                             S_AXI_ARREGION, S_AXI_ARUSER};

    axi_burst_addr_next #(.ADDR_W(AW)) u_w_addr (
        .addr      (aw_addr_q),
        .size      (aw_size_q),
        .len       (aw_len_q),
        .burst     (aw_burst_q),
        .addr_next (w_addr_next)
    );

    axi_burst_addr_next #(.ADDR_W(AW)) u_r_addr (
        .addr      (r_gen_addr),
        .size      (r_gen_size),
        .len       (r_gen_len),
        .burst     (r_gen_burst),
        .addr_next (r_addr_next)
    );

    // Write FSM: beat count, not WLAST, decides the end of the data phase
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_fire     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && awready_q) begin
                    aw_id_d    = S_AXI_AWID;
                    aw_addr_d  = S_AXI_AWADDR;
                    aw_len_d   = S_AXI_AWLEN;
                    aw_size_d  = S_AXI_AWSIZE;
                    aw_burst_d = S_AXI_AWBURST;
                    w_cnt_d    = 8'd0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID && wready_q) begin
                    w_fire    = 1'b1;
                    aw_addr_d = w_addr_next;
                    w_cnt_d   = w_cnt_q + 8'd1;
                    if (w_cnt_q == aw_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY && bvalid_q) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Byte-lane merge of the incoming beat into the current word contents
    always_comb begin
        w_idx      = aw_addr_q[ADDR_LSB +: IDX_W];
        w_old_word = written_q[w_idx] ? mem_q[w_idx] : DW'(w_idx);
        wr_word_d  = w_old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (S_AXI_WSTRB[b]) wr_word_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
    end

    // Read FSM: the address generator follows ARADDR while idle, the saved address otherwise
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        rdata_d    = rdata_q;
        rlast_d    = rlast_q;
        r_gen_addr  = (r_state_q == R_IDLE) ? S_AXI_ARADDR  : ar_addr_q;
        r_gen_size  = (r_state_q == R_IDLE) ? S_AXI_ARSIZE  : ar_size_q;
        r_gen_len   = (r_state_q == R_IDLE) ? S_AXI_ARLEN   : ar_len_q;
        r_gen_burst = (r_state_q == R_IDLE) ? S_AXI_ARBURST : ar_burst_q;
        r_idx       = r_gen_addr[ADDR_LSB +: IDX_W];
        r_word      = written_q[r_idx] ? mem_q[r_idx] : DW'(r_idx);
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    ar_id_d    = S_AXI_ARID;
                    ar_len_d   = S_AXI_ARLEN;
                    ar_size_d  = S_AXI_ARSIZE;
                    ar_burst_d = S_AXI_ARBURST;
                    ar_addr_d  = r_addr_next;
                    r_cnt_d    = 8'd0;
                    rdata_d    = r_word;
                    rlast_d    = (S_AXI_ARLEN == 8'd0);
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_d   = r_word;
                        ar_addr_d = r_addr_next;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // Control and handshake registers; memory contents survive reset
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
        end
    end

    // Word array update on each accepted write beat
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_fire) begin
            mem_q[w_idx]     <= wr_word_d;
            written_q[w_idx] <= 1'b1;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = aw_id_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_BUSER   = '0;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = ar_id_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RUSER   = '0;

endmodule

// File: tb/tb_virtual_axi_full_memory.sv
// Self-checking bench for virtual_axi_full_memory against a word-array reference model.
module tb_virtual_axi_full_memory;

    localparam int DW    = 128;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [0:0]    awid, bid, arid, rid;
    logic [63:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awlock, arlock;
    logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
    logic [0:0]    awuser, aruser, wuser, buser, ruser;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [15:0]   wstrb;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wq_data [$];
    logic [15:0]   wq_strb [$];
    logic [DW-1:0] rd_q [$];
    logic          last_q [$];
    logic [0:0]    id_q [$];
    logic [1:0]    resp_q [$];
    logic [1:0]    b_resp;
    logic [0:0]    b_id;
    int            b_extra;
    int            unstable;
    logic          first_ok;

    virtual_axi_full_memory dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(awlock), .S_AXI_AWCACHE(awcache),
        .S_AXI_AWPROT(awprot), .S_AXI_AWQOS(awqos), .S_AXI_AWREGION(awregion),
        .S_AXI_AWUSER(awuser), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(wuser),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(arlock), .S_AXI_ARCACHE(arcache),
        .S_AXI_ARPROT(arprot), .S_AXI_ARQOS(arqos), .S_AXI_ARREGION(arregion),
        .S_AXI_ARUSER(aruser), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    // Byte address of beat i of a burst, straight from the AXI4 burst rules
    function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [2:0] size,
                                              input int len, input logic [1:0] burst, input int i);
        logic [63:0] step, wrap, base;
        step = 64'd1 << size;
        wrap = 64'(len + 1) * step;
        base = a - (a % wrap);
        case (burst)
            2'b00:   return a;
            2'b10:   return base + ((a - base + 64'(i) * step) % wrap);
            default: return a + 64'(i) * step;
        endcase
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a >> 4) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [0:0] id);
        int t;
        int idx;
        awid = id; awaddr = addr; awlen = len[7:0]; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 200) begin tick(); t++; end
        if (t >= 200) begin tests++; fails++; $display("FAIL aw_timeout: awready=%0b required 1", awready); end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == len); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 200) begin tick(); t++; end
            if (t >= 200) begin tests++; fails++; $display("FAIL w_timeout: wready=%0b required 1", wready); end
            tick();
            idx = widx(beat_addr(addr, size, len, burst, i));
            for (int b = 0; b < 16; b++)
                if (wq_strb[i][b]) model[idx][8*b +: 8] = wq_data[i][8*b +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 200) begin tick(); t++; end
        if (t >= 200) begin tests++; fails++; $display("FAIL b_timeout: bvalid=%0b required 1", bvalid); end
        b_id = bid; b_resp = bresp;
        tick();
        bready = 1'b0;
        b_extra = 0;
        repeat (3) begin
            if (bvalid) b_extra++;
            tick();
        end
    endtask

    task automatic axi_read(input logic [63:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [0:0] id, input bit toggle);
        int t;
        int cyc;
        bit hold;
        logic [DW-1:0] h_data;
        logic h_last;
        logic [0:0] h_id;
        rd_q.delete(); last_q.delete(); id_q.delete(); resp_q.delete();
        unstable = 0;
        arid = id; araddr = addr; arlen = len[7:0]; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 200) begin tick(); t++; end
        if (t >= 200) begin tests++; fails++; $display("FAIL ar_timeout: arready=%0b required 1", arready); end
        tick();
        arvalid = 1'b0;
        first_ok = rvalid;
        cyc = 0; hold = 0; h_data = '0; h_last = 1'b0; h_id = '0;
        while (rd_q.size() < len + 1 && cyc < 500) begin
            rready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (rvalid) begin
                if (hold && (rdata !== h_data || rlast !== h_last || rid !== h_id)) unstable++;
                if (rready) begin
                    rd_q.push_back(rdata); last_q.push_back(rlast);
                    id_q.push_back(rid); resp_q.push_back(rresp);
                    hold = 0;
                end else begin
                    hold = 1; h_data = rdata; h_last = rlast; h_id = rid;
                end
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 500) begin tests++; fails++; $display("FAIL r_timeout: beats=%0d required %0d", rd_q.size(), len + 1); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            fails++; $display("FAIL reset_handshakes: got %b required 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        end
        tests++;
        if ({rdata, rid, bid, bresp, rresp} !== '0) begin
            fails++; $display("FAIL reset_data: rdata=%h rid=%0d bid=%0d bresp=%0d rresp=%0d required all 0", rdata, rid, bid, bresp, rresp);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: awready=%0b arready=%0b required 1 1", awready, arready);
        end
    endtask

    task automatic test_single_read();
        axi_read(64'h30, 0, 3'd4, 2'b01, 1'b1, 1'b0);
        tests++;
        if (first_ok !== 1'b1) begin fails++; $display("FAIL single_latency: rvalid=%0b required 1", first_ok); end
        tests++;
        if (rd_q.size() != 1 || rd_q[0] !== 128'd3 || last_q[0] !== 1'b1 || resp_q[0] !== 2'b00 || id_q[0] !== 1'b1) begin
            fails++; $display("FAIL single_read: beats=%0d data=%h last=%0b resp=%0d id=%0d required 1 3 1 0 1",
                              rd_q.size(), rd_q[0], last_q[0], resp_q[0], id_q[0]);
        end
        tests++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            fails++; $display("FAIL single_after: rvalid=%0b arready=%0b required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_incr_burst();
        int nlast;
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i < 16; i++) begin wq_data.push_back(DW'(i + 'hA0)); wq_strb.push_back(16'hFFFF); end
        axi_write(64'h1000, 15, 3'd4, 2'b01, 1'b0);
        tests++;
        if (b_resp !== 2'b00 || b_id !== 1'b0 || b_extra != 0) begin
            fails++; $display("FAIL incr_bresp: bresp=%0d bid=%0d extra_b=%0d required 0 0 0", b_resp, b_id, b_extra);
        end
        axi_read(64'h1000, 15, 3'd4, 2'b01, 1'b0, 1'b0);
        nlast = 0;
        for (int i = 0; i < rd_q.size(); i++) begin
            if (last_q[i]) nlast++;
            tests++;
            if (rd_q[i] !== DW'(i + 'hA0)) begin
                fails++; $display("FAIL incr_data[%0d]: got %h required %h", i, rd_q[i], DW'(i + 'hA0));
            end
        end
        tests++;
        if (rd_q.size() != 16 || nlast != 1 || last_q[15] !== 1'b1) begin
            fails++; $display("FAIL incr_rlast: beats=%0d lasts=%0d required 16 1 on beat 16", rd_q.size(), nlast);
        end
    endtask

    task automatic test_strobe();
        wq_data.delete(); wq_strb.delete();
        wq_data.push_back({DW{1'b1}}); wq_strb.push_back(16'h000F);
        axi_write(64'h50, 0, 3'd4, 2'b01, 1'b0);
        axi_read(64'h50, 0, 3'd4, 2'b01, 1'b0, 1'b0);
        tests++;
        if (rd_q[0] !== 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF) begin
            fails++; $display("FAIL strobe_low32: got %h required 000000000000000000000000ffffffff", rd_q[0]);
        end
        wq_data.delete(); wq_strb.delete();
        wq_data.push_back({DW{1'b1}}); wq_strb.push_back(16'h0001);
        axi_write(64'h1230, 0, 3'd4, 2'b01, 1'b0);
        axi_read(64'h1230, 0, 3'd4, 2'b01, 1'b0, 1'b0);
        tests++;
        if (rd_q[0] !== 128'h1FF) begin
            fails++; $display("FAIL strobe_byte0: got %h required 1ff", rd_q[0]);
        end
    endtask

    task automatic test_wrap_read();
        logic [7:0] exp_lo [4];
        exp_lo[0] = 8'hA3; exp_lo[1] = 8'hA0; exp_lo[2] = 8'hA1; exp_lo[3] = 8'hA2;
        axi_read(64'h1030, 3, 3'd4, 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rd_q[i] !== DW'(exp_lo[i]) || last_q[i] !== (i == 3)) begin
                fails++; $display("FAIL wrap_beat[%0d]: got %h last=%0b required %h last=%0b", i, rd_q[i], last_q[i], DW'(exp_lo[i]), (i == 3));
            end
        end
    endtask

    task automatic test_rready_toggle();
        axi_read(64'h1000, 7, 3'd4, 2'b01, 1'b0, 1'b1);
        tests++;
        if (unstable != 0 || rd_q.size() != 8) begin
            fails++; $display("FAIL toggle_hold: unstable=%0d beats=%0d required 0 8", unstable, rd_q.size());
        end
        for (int i = 0; i < rd_q.size(); i++) begin
            tests++;
            if (rd_q[i] !== model[widx(64'h1000 + 64'(16 * i))] || last_q[i] !== (i == 7)) begin
                fails++; $display("FAIL toggle_beat[%0d]: got %h last=%0b required %h last=%0b", i, rd_q[i], last_q[i],
                                  model[widx(64'h1000 + 64'(16 * i))], (i == 7));
            end
        end
    endtask

    task automatic test_random_bursts();
        logic [63:0] addr;
        logic [1:0]  burst;
        logic [2:0]  size;
        int          len;
        for (int n = 0; n < 8; n++) begin
            burst = 2'($urandom_range(0, 3));
            size  = 3'($urandom_range(0, 4));
            len   = (burst == 2'b10) ? ((2 << $urandom_range(0, 3)) - 1) : int'($urandom_range(0, 15));
            addr  = 64'($urandom_range(0, 'hFFFF)) & ~64'hF;
            wq_data.delete(); wq_strb.delete();
            for (int i = 0; i <= len; i++) begin wq_data.push_back(rand_word()); wq_strb.push_back(16'($urandom)); end
            axi_write(addr, len, size, burst, 1'(n));
            tests++;
            if (b_id !== 1'(n) || b_resp !== 2'b00 || b_extra != 0) begin
                fails++; $display("FAIL rand_b[%0d]: bid=%0d bresp=%0d extra=%0d required %0d 0 0", n, b_id, b_resp, b_extra, n % 2);
            end
            axi_read(addr, len, size, burst, 1'(n + 1), 1'($urandom));
            for (int i = 0; i < rd_q.size(); i++) begin
                tests++;
                if (rd_q[i] !== model[widx(beat_addr(addr, size, len, burst, i))] || id_q[i] !== 1'(n + 1)) begin
                    fails++; $display("FAIL rand_r[%0d][%0d]: got %h id=%0d required %h id=%0d", n, i, rd_q[i], id_q[i],
                                      model[widx(beat_addr(addr, size, len, burst, i))], (n + 1) % 2);
                end
            end
            tests++;
            if (unstable != 0 || rd_q.size() != len + 1 || last_q[len] !== 1'b1) begin
                fails++; $display("FAIL rand_shape[%0d]: unstable=%0d beats=%0d required 0 %0d", n, unstable, rd_q.size(), len + 1);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int t;
        logic [DW-1:0] d;
        awid = 1'b0; awaddr = 64'h2000; awlen = 8'd7; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 200) begin tick(); t++; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = rand_word();
            wdata = d; wstrb = 16'hFFFF; wlast = 1'b0; wvalid = 1'b1;
            t = 0;
            while (!wready && t < 200) begin tick(); t++; end
            tick();
            model[widx(64'h2000 + 64'(16 * i))] = d;
        end
        wvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            fails++; $display("FAIL midreset_outputs: got %b required 00000", {awready, wready, bvalid, arready, rvalid});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            fails++; $display("FAIL midreset_ready: awready=%0b arready=%0b required 1 1", awready, arready);
        end
        axi_read(64'h2000, 7, 3'd4, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < rd_q.size(); i++) begin
            tests++;
            if (rd_q[i] !== model[widx(64'h2000 + 64'(16 * i))]) begin
                fails++; $display("FAIL midreset_mem[%0d]: got %h required %h", i, rd_q[i], model[widx(64'h2000 + 64'(16 * i))]);
            end
        end
        wq_data.delete(); wq_strb.delete();
        wq_data.push_back(rand_word()); wq_data.push_back(rand_word());
        wq_strb.push_back(16'hFFFF); wq_strb.push_back(16'hFFFF);
        axi_write(64'h2040, 1, 3'd4, 2'b01, 1'b1);
        axi_read(64'h2040, 1, 3'd4, 2'b01, 1'b1, 1'b0);
        tests++;
        if (b_resp !== 2'b00 || b_id !== 1'b1 || rd_q[0] !== wq_data[0] || rd_q[1] !== wq_data[1]) begin
            fails++; $display("FAIL midreset_new_txn: bresp=%0d bid=%0d r0=%h r1=%h required 0 1 %h %h",
                              b_resp, b_id, rd_q[0], rd_q[1], wq_data[0], wq_data[1]);
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) model[k] = DW'(k);
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0; awcache = '0;
        awprot = '0; awqos = '0; awregion = '0; awuser = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0; arcache = '0;
        arprot = '0; arqos = '0; arregion = '0; aruser = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single_read();
        test_incr_burst();
        test_strobe();
        test_wrap_read();
        test_rready_toggle();
        test_random_bursts();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
